// File: rtl/regfile_pkg.sv
// Shared register-file sizing for the operand read stage.
package regfile_pkg;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit tracking for in-flight destinations and RAW/WAW hazard detection.
// REGREAD_BYPASS_EN: a source being written back this cycle is not a RAW hazard.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS = regfile_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic          dst_en,
  input  logic [AW-1:0] dst_addr,
  input  logic          set_en,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  output logic          raw_hazard,
  output logic          waw_hazard
);
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic rs1_busy, rs2_busy, dst_busy, dst_clr;

  // Clear first so a same-address issue in the writeback cycle keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (set_en && dst_addr != '0) busy_d[dst_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1_addr] && (rs1_addr != '0);
  assign rs2_busy = busy_q[rs2_addr] && (rs2_addr != '0);
  assign dst_busy = busy_q[dst_addr] && (dst_addr != '0);
  assign dst_clr  = wb_en && (wb_addr == dst_addr);

`ifdef REGREAD_BYPASS_EN
  logic rs1_clr, rs2_clr;
  assign rs1_clr    = wb_en && (wb_addr == rs1_addr);
  assign rs2_clr    = wb_en && (wb_addr == rs2_addr);
  assign raw_hazard = (rs1_busy && !rs1_clr) || (rs2_busy && !rs2_clr);
`else
  assign raw_hazard = rs1_busy || rs2_busy;
`endif

  assign waw_hazard = dst_en && dst_busy && !dst_clr;
endmodule

// File: rtl/reg_read_unit.sv
// Register read stage: register file, scoreboard interlock and a one-entry operand register.
// REGREAD_BYPASS_EN: forward same-cycle writeback data into the operands.
module reg_read_unit
  import regfile_pkg::*;
#(
  parameter int  XLEN  = regfile_pkg::XLEN,
  parameter int  NREGS = regfile_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_valid,
  output logic            rd_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            dst_en,
  input  logic [AW-1:0]   dst_addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            out_valid_q, out_valid_d;
  logic            raw_hazard, waw_hazard, accept;

  reg_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .dst_en     (dst_en),
    .dst_addr   (dst_addr),
    .set_en     (accept && dst_en),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .raw_hazard (raw_hazard),
    .waw_hazard (waw_hazard)
  );

  assign rd_ready = !raw_hazard && !waw_hazard && (!out_valid_q || out_ready);
  assign accept   = rd_valid && rd_ready;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = rf_q[rs1_addr];
    rs2_val = rf_q[rs2_addr];
`ifdef REGREAD_BYPASS_EN
    if (wb_en && wb_addr == rs1_addr) rs1_val = wb_data;
    if (wb_en && wb_addr == rs2_addr) rs2_val = wb_data;
`endif
    if (rs1_addr == '0) rs1_val = '0;
    if (rs2_addr == '0) rs2_val = '0;

    out_valid_d = out_valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    if (accept) begin
      out_valid_d = 1'b1;
      rs1_d       = rs1_val;
      rs2_d       = rs2_val;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
endmodule

// File: tb/tb_reg_read_unit.sv
// Self-checking bench for reg_read_unit; expected operands queued at accept, compared at output.
module tb_reg_read_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd_valid, rd_ready;
  logic [4:0]  rs1_addr, rs2_addr, dst_addr, wb_addr;
  logic        dst_en, wb_en, out_valid, out_ready;
  logic [31:0] wb_data, rs1_data, rs2_data;

  always #5 clk = ~clk;

  reg_read_unit #(.XLEN(32), .NREGS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .dst_en    (dst_en),
    .dst_addr  (dst_addr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data)
  );

`ifdef REGREAD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [32];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  function automatic logic [31:0] src_val(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && wb_en && wb_addr == a) return wb_data;
    return model[a];
  endfunction

  task automatic push_accept();
    exp_t e;
    e.r1 = src_val(rs1_addr);
    e.r2 = src_val(rs2_addr);
    exp_q.push_back(e);
    $display("accept rs1=x%0d rs2=x%0d dst_en=%b dst=x%0d exp=%h/%h",
             rs1_addr, rs2_addr, dst_en, dst_addr, e.r1, e.r2);
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.r1 = 'x;
      e.r2 = 'x;
    end
  endtask

  // Advance from before an edge to just after it, committing any pending writeback to the model.
  task automatic tick();
    if (wb_en && wb_addr != 5'd0) model[wb_addr] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    tick();
    wb_en = 1'b0;
    $display("writeback x%0d=%h", a, d);
  endtask

  task automatic do_issue(input logic [4:0] a1, input logic [4:0] a2, input logic den,
                          input logic [4:0] dst, output int waited);
    rd_valid = 1'b1; rs1_addr = a1; rs2_addr = a2; dst_en = den; dst_addr = dst;
    waited = 0;
    @(negedge clk);
    while (!rd_ready && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (rd_ready) push_accept();
    else waited = -1;
    tick();
    rd_valid = 1'b0; dst_en = 1'b0; rs1_addr = '0; rs2_addr = '0; dst_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; dst_en = 1'b0;
    dst_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'h0) $display("FAIL reset_rs1_data: got %h expected 0", rs1_data); else pass_cnt++;
    total_cnt++; if (rs2_data !== 32'h0) $display("FAIL reset_rs2_data: got %h expected 0", rs2_data); else pass_cnt++;
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL reset_rd_ready: got %b expected 1", rd_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_basic_read();
    int w;
    exp_t e;
    do_wb(5'd5, 32'hDEADBEEF);
    do_issue(5'd5, 5'd0, 1'b0, 5'd0, w);
    total_cnt++; if (w !== 0) $display("FAIL basic_accept: waited %0d expected 0", w); else pass_cnt++;
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (rs1_data !== 32'hDEADBEEF || rs1_data !== e.r1) $display("FAIL basic_rs1: got %h expected %h", rs1_data, e.r1); else pass_cnt++;
    total_cnt++; if (rs2_data !== 32'h0) $display("FAIL basic_rs2: got %h expected 0", rs2_data); else pass_cnt++;
    tick();
    do_wb(5'd10, 32'hA5A5A5A5);
    do_wb(5'd11, 32'h0F0F1234);
    do_issue(5'd11, 5'd10, 1'b0, 5'd0, w);
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== e.r1 || rs2_data !== e.r2)
      $display("FAIL basic_pair: got v=%b %h/%h expected v=1 %h/%h", out_valid, rs1_data, rs2_data, e.r1, e.r2); else pass_cnt++;
    tick();
  endtask

  task automatic test_raw_stall();
    int w, acc_cycle;
    exp_t e;
    do_issue(5'd0, 5'd0, 1'b1, 5'd7, w);
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== e.r1) $display("FAIL raw_issue_dst7: got v=%b %h expected v=1 %h", out_valid, rs1_data, e.r1); else pass_cnt++;
    tick();
    rd_valid = 1'b1; rs1_addr = 5'd7; rs2_addr = 5'd5; dst_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++; if (rd_ready !== 1'b0) $display("FAIL raw_stall: cycle %0d rd_ready=%b expected 0", i, rd_ready); else pass_cnt++;
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
    acc_cycle = -1;
    for (int i = 0; i < 3 && acc_cycle < 0; i++) begin
      @(negedge clk);
      if (rd_ready) begin
        acc_cycle = i;
        push_accept();
      end
      tick();
      wb_en = 1'b0;
    end
    rd_valid = 1'b0;
    total_cnt++; if (acc_cycle !== (BYPASS ? 0 : 1)) $display("FAIL raw_accept_cycle: got %0d expected %0d", acc_cycle, BYPASS ? 0 : 1); else pass_cnt++;
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== 32'h12345678 || rs2_data !== e.r2)
      $display("FAIL raw_data: got v=%b %h/%h expected v=1 12345678/%h", out_valid, rs1_data, rs2_data, e.r2); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    int w;
    exp_t e;
    out_ready = 1'b0;
    do_issue(5'd5, 5'd10, 1'b0, 5'd0, w);
    total_cnt++; if (w !== 0) $display("FAIL bp_first_accept: waited %0d expected 0", w); else pass_cnt++;
    rd_valid = 1'b1; rs1_addr = 5'd11; rs2_addr = 5'd5;
    pop_exp(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1 || rs1_data !== e.r1 || rs2_data !== e.r2)
        $display("FAIL bp_hold: cycle %0d got v=%b %h/%h expected v=1 %h/%h", i, out_valid, rs1_data, rs2_data, e.r1, e.r2); else pass_cnt++;
      total_cnt++; if (rd_ready !== 1'b0) $display("FAIL bp_stall: cycle %0d rd_ready=%b expected 0", i, rd_ready); else pass_cnt++;
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL bp_release: rd_ready=%b expected 1", rd_ready); else pass_cnt++;
    if (rd_ready) push_accept();
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== e.r1 || rs2_data !== e.r2)
      $display("FAIL bp_next_data: got v=%b %h/%h expected v=1 %h/%h", out_valid, rs1_data, rs2_data, e.r1, e.r2); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain: out_valid=%b expected 0", out_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_waw();
    int w;
    exp_t e;
    do_issue(5'd0, 5'd0, 1'b1, 5'd9, w);
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== e.r1) $display("FAIL waw_issue_dst9: got v=%b %h expected v=1 %h", out_valid, rs1_data, e.r1); else pass_cnt++;
    tick();
    rd_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd0; dst_en = 1'b1; dst_addr = 5'd9;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000099;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL waw_clear_same_cycle: rd_ready=%b expected 1", rd_ready); else pass_cnt++;
    if (rd_ready) push_accept();
    tick();
    wb_en = 1'b0;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b0) $display("FAIL waw_set_wins: rd_ready=%b expected 0", rd_ready); else pass_cnt++;
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== e.r1) $display("FAIL waw_data: got v=%b %h expected v=1 %h", out_valid, rs1_data, e.r1); else pass_cnt++;
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b0) $display("FAIL waw_no_valid_dep: rd_ready=%b expected 0", rd_ready); else pass_cnt++;
    tick();
    dst_en = 1'b0; rs1_addr = 5'd9;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b0) $display("FAIL raw_on_x9: rd_ready=%b expected 0", rd_ready); else pass_cnt++;
    tick();
    do_wb(5'd9, 32'h00000909);
    dst_en = 1'b1; dst_addr = 5'd9;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL waw_busy_cleared: rd_ready=%b expected 1", rd_ready); else pass_cnt++;
    tick();
    dst_en = 1'b0; dst_addr = '0; rs1_addr = '0;
  endtask

  task automatic test_reset_inflight();
    int w;
    exp_t e;
    do_wb(5'd3, 32'h33333333);
    out_ready = 1'b0;
    do_issue(5'd5, 5'd3, 1'b1, 5'd3, w);
    @(negedge clk);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL rst_pre_valid: out_valid=%b expected 1", out_valid); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || rs1_data !== 32'h0 || rs2_data !== 32'h0)
      $display("FAIL rst_async_clear: got v=%b %h/%h expected v=0 0/0", out_valid, rs1_data, rs2_data); else pass_cnt++;
    exp_q.delete();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    rd_valid = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd5; dst_en = 1'b1; dst_addr = 5'd3;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL rst_busy_cleared: rd_ready=%b expected 1", rd_ready); else pass_cnt++;
    if (rd_ready) push_accept();
    tick();
    rd_valid = 1'b0; dst_en = 1'b0;
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== 32'h0 || rs2_data !== e.r2)
      $display("FAIL rst_storage_zero: got v=%b %h/%h expected v=1 0/%h", out_valid, rs1_data, rs2_data, e.r2); else pass_cnt++;
    tick();
  endtask

  task automatic test_x0();
    exp_t e;
    rd_valid = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0; dst_en = 1'b1; dst_addr = 5'd0;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL x0_issue: rd_ready=%b expected 1", rd_ready); else pass_cnt++;
    if (rd_ready) push_accept();
    tick();
    wb_en = 1'b0; dst_en = 1'b0;
    @(negedge clk);
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL x0_no_stall: rd_ready=%b expected 1", rd_ready); else pass_cnt++;
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== 32'h0 || rs1_data !== e.r1)
      $display("FAIL x0_read_first: got v=%b %h expected v=1 0", out_valid, rs1_data); else pass_cnt++;
    if (rd_ready) push_accept();
    tick();
    rd_valid = 1'b0;
    @(negedge clk);
    pop_exp(e);
    total_cnt++; if (out_valid !== 1'b1 || rs1_data !== 32'h0 || rs2_data !== e.r2)
      $display("FAIL x0_read_second: got v=%b %h/%h expected v=1 0/0", out_valid, rs1_data, rs2_data); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_raw_stall();
    test_backpressure();
    test_waw();
    test_reset_inflight();
    test_x0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_read_unit.md
REG_READ_UNIT -- requirements
Module: reg_read_unit

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, number of architectural registers; address width is log2(NREGS).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rd_valid  input  1  decode presents a read request.
REQ-006 rd_ready  output  1  unit accepts the request this cycle.
REQ-007 rs1_addr, rs2_addr  input  5 each  source register addresses.
REQ-008 dst_en  input  1  the accepted instruction will write dst_addr.
REQ-009 dst_addr  input  5  destination register of the issuing instruction.
REQ-010 wb_en  input  1  writeback write strobe.
REQ-011 wb_addr  input  5  writeback register address.
REQ-012 wb_data  input  XLEN  writeback data.
REQ-013 out_valid  output  1  operand register holds valid operands.
REQ-014 out_ready  input  1  downstream stage accepts the operands.
REQ-015 rs1_data, rs2_data  output  XLEN each  registered operands.

Function
REQ-016 Storage SHALL be an NREGS x XLEN array written on rising clk when wb_en=1 and wb_addr!=0.
REQ-017 Register 0 SHALL always read 0; writes to it SHALL be ignored; its busy bit SHALL never set.
REQ-018 A request SHALL be accepted when rd_valid=1 and rd_ready=1 in the same cycle.
REQ-019 A RAW hazard SHALL exist when a nonzero rs1_addr or rs2_addr is busy and is not being cleared by wb this cycle.
REQ-020 A WAW hazard SHALL exist when dst_en=1 and a nonzero dst_addr is busy and is not being cleared this cycle.
REQ-021 rd_ready SHALL be 1 only when there is no RAW hazard, no WAW hazard, and either out_valid=0 or out_ready=1; rd_ready SHALL NOT depend on rd_valid.
REQ-022 Latency: operands of an accepted request SHALL appear on rs1_data/rs2_data with out_valid=1 on the next rising edge.
REQ-023 When out_valid=1 and out_ready=0, the operand register and out_valid SHALL hold.
REQ-024 out_valid SHALL clear after a handshake (out_valid and out_ready both 1) in which no new request is accepted.
REQ-025 On accept with dst_en=1 and dst_addr!=0, busy[dst_addr] SHALL set on the next edge.
REQ-026 wb_en=1 SHALL clear busy[wb_addr] on the next edge; on simultaneous set and clear of the same address, the set SHALL win.
REQ-027 Operands for a source register equal to dst_addr of the same request SHALL read the pre-write value.

Reset
REQ-028 Asserting reset SHALL immediately clear all busy bits, out_valid, rs1_data, rs2_data and every storage entry to 0.
REQ-029 A request in flight when reset asserts SHALL be discarded; rd_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-030 Macro REGREAD_BYPASS_EN.
- Defined: when wb_en=1 and wb_addr equals a nonzero source, the operand SHALL be wb_data, and that source SHALL NOT cause a RAW hazard.
- Undefined: no bypass. A busy source SHALL stall until its busy bit is clear, so the read occurs no earlier than one cycle after writeback.

Structure
REQ-031 A package regfile_pkg SHALL hold XLEN, NREGS, the address-width constant and a reg_addr_t typedef.
REQ-032 The busy-bit vector and its set/clear/hazard logic SHALL be a sub-module named reg_scoreboard.

Verification
REQ-033 After reset: wb x5=0xDEADBEEF, then a request with rs1=5 and rs2=0 -> next cycle out_valid=1, rs1_data=0xDEADBEEF, rs2_data=0.
REQ-034 Issue with dst=7, then a request with rs1=7 -> rd_ready=0 until wb x7=0x12345678. With REGREAD_BYPASS_EN the accept occurs in the wb cycle and rs1_data=0x12345678; without it the accept occurs one cycle later with the same value.
REQ-035 With out_ready held 0 for 3 cycles -> operands and out_valid stable and rd_ready=0; releasing out_ready -> the next request is accepted in that cycle.
REQ-036 Same cycle: wb x9 and accept with dst=9 -> busy[9]=1 afterward. Issue with dst=9 while busy -> rd_ready=0 (WAW hazard).
REQ-037 Assert reset while out_valid=1 and busy[3]=1 -> out_valid=0, busy clear and x3 reads 0 after release.
REQ-038 wb x0=0xFFFFFFFF and issue with dst=0 -> a request with rs1=0 is never stalled and returns 0.
